// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared definitions for the step sequencer.
//   state_e     : FSM state encodings (ST_IDLE..ST_ERROR)
//   ERR_*       : err_code values reported to the controller
package step_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_NEXT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FAIL    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/seq_timer.sv
// seq_timer: saturating cycle counter used to time one request.
//   clk, rstn  : clock, synchronous active-low reset
//   clr_i      : force count to 0 (has priority over en_i)
//   en_i       : count up by one per cycle, saturating at all-ones
//   limit_i    : compare value
//   expired_o  : count has reached limit_i
module seq_timer #(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expired_o
);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn)                          cnt_q <= '0;
    else if (clr_i)                     cnt_q <= '0;
    else if (en_i && (cnt_q != '1))     cnt_q <= cnt_q + TO_W'(1);
  end

  assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: runs N_STEPS request/acknowledge steps on one engine
// channel, with per-step timeout, abort and sticky error capture.
//   clk, rstn        : clock, synchronous active-low reset
//   start            : begin a sequence from IDLE or ERROR (ignored while busy)
//   abort            : return to IDLE from any state (highest priority)
//   step_ack/_fail   : engine completion for the current step, fail qualifier
//   step_req/step_idx: request for step step_idx, held until ack
//   busy             : high in REQ and NEXT
//   done             : one-cycle pulse after the last step succeeds
//   err/err_code/err_step : sticky error flag, cause and failing step
// Optional build macro: STEP_SEQ_RETRY_EN enables up to MAX_RETRY re-issues
// of a failed or timed-out step before ERROR is entered.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int N_STEPS   = 16,
  parameter int STEP_W    = 4,
  parameter int TO_W      = 8,
  parameter int TIMEOUT   = 200,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              step_ack,
  input  logic              step_fail,
  output logic              step_req,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [STEP_W-1:0] err_step
);

  localparam logic [STEP_W-1:0] LAST   = STEP_W'(N_STEPS - 1);
  // Expiry on the TIMEOUT-th REQ cycle: the count is TIMEOUT-1 then.
  localparam logic [TO_W-1:0]   TO_LIM = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              step_req_q, busy_q, done_q, err_q;
  logic [STEP_W-1:0] step_idx_q, err_step_q;
  logic [1:0]        err_code_q;

`ifdef STEP_SEQ_RETRY_EN
  localparam int               RTY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [RTY_W-1:0] MAX_RTY = RTY_W'(MAX_RETRY);
  logic [RTY_W-1:0]            retry_q;
`endif

  logic       tmr_exp, to_hit, fault;
  logic [1:0] cause;

  seq_timer #(.TO_W(TO_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (state_q != ST_REQ),
    .en_i     (state_q == ST_REQ),
    .limit_i  (TO_LIM),
    .expired_o(tmr_exp)
  );

  // An ack always wins over a coincident timeout.
  assign to_hit = (TIMEOUT != 0) && tmr_exp;
  assign fault  = step_ack ? step_fail : to_hit;
  assign cause  = step_ack ? ERR_FAIL : ERR_TIMEOUT;

  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      state_q    <= ST_IDLE;
      step_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_step_q <= '0;
      step_idx_q <= '0;
`ifdef STEP_SEQ_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q    <= ST_REQ;
          step_req_q <= 1'b1;
          busy_q     <= 1'b1;
          step_idx_q <= '0;
        end
        ST_REQ: begin
          if (step_ack && !step_fail) begin
`ifdef STEP_SEQ_RETRY_EN
            retry_q    <= '0;
`endif
            step_req_q <= 1'b0;
            if (step_idx_q == LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Index advances on entry to the gap cycle.
              state_q    <= ST_NEXT;
              step_idx_q <= step_idx_q + STEP_W'(1);
            end
          end else if (fault) begin
            step_req_q <= 1'b0;
`ifdef STEP_SEQ_RETRY_EN
            if (retry_q < MAX_RTY) begin
              // Re-issue the same step after the gap cycle.
              retry_q <= retry_q + RTY_W'(1);
              state_q <= ST_NEXT;
            end else
`endif
            begin
              state_q    <= ST_ERROR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= cause;
              err_step_q <= step_idx_q;
`ifdef STEP_SEQ_RETRY_EN
              retry_q    <= '0;
`endif
            end
          end
        end
        ST_NEXT: begin
          state_q    <= ST_REQ;
          step_req_q <= 1'b1;
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          done_q     <= 1'b0;
          step_idx_q <= '0;
        end
        ST_ERROR: if (start) begin
          state_q    <= ST_REQ;
          step_req_q <= 1'b1;
          busy_q     <= 1'b1;
          err_q      <= 1'b0;
          err_code_q <= ERR_NONE;
          err_step_q <= '0;
          step_idx_q <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          step_req_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          err_code_q <= ERR_NONE;
          err_step_q <= '0;
          step_idx_q <= '0;
`ifdef STEP_SEQ_RETRY_EN
          retry_q    <= '0;
`endif
        end
      endcase
    end
  end

  assign step_req = step_req_q;
  assign step_idx = step_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_step = err_step_q;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed self-checking bench for step_sequencer
// (N_STEPS=4, TIMEOUT=10, MAX_RETRY=2). Retry-specific sequences run when
// STEP_SEQ_RETRY_EN is defined.
module tb_step_sequencer;

  localparam int STEP_W = 4;
`ifdef STEP_SEQ_RETRY_EN
  localparam int RTY = 2;
`else
  localparam int RTY = 0;
`endif

  logic              clk = 1'b0;
  logic              rstn, start, abort, step_ack, step_fail;
  logic              step_req, busy, done, err;
  logic [STEP_W-1:0] step_idx, err_step;
  logic [1:0]        err_code;

  int nchk = 0;
  int nerr = 0;

  step_sequencer #(
    .N_STEPS(4), .STEP_W(STEP_W), .TO_W(8), .TIMEOUT(10), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .step_ack(step_ack), .step_fail(step_fail),
    .step_req(step_req), .step_idx(step_idx), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .err_step(err_step)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first REQ cycle of step idx; acks on the dly-th REQ cycle.
  task automatic do_step(input int idx, input int dly, input bit last);
    chk("req_hi", step_req, 1);
    chk("idx", step_idx, idx);
    repeat (dly - 1) tick();
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    if (last) begin
      chk("done_pulse", done, 1);
      chk("done_req", step_req, 0);
      chk("done_busy", busy, 0);
      tick();
      chk("done_clr", done, 0);
      chk("idx_clr", step_idx, 0);
    end else begin
      chk("gap_req", step_req, 0);
      chk("gap_busy", busy, 1);
      chk("gap_idx", step_idx, idx + 1);
      tick();
    end
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; step_ack = 1'b0; step_fail = 1'b0;
    tick(); tick();
    chk("rst_outs", {step_req, step_idx, busy, done, err, err_code, err_step}, 0);
    rstn = 1'b1;

    // Ack while idle is ignored.
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    chk("idle_ack_req", step_req, 0);
    chk("idle_ack_busy", busy, 0);

    // 1: full sequence, ack 3 cycles after each req; start while busy ignored.
    go();
    chk("t1_busy", busy, 1);
    do_step(0, 3, 0);
    start = 1'b1;
    do_step(1, 3, 0);
    start = 1'b0;
    do_step(2, 3, 0);
    do_step(3, 3, 1);
    chk("t1_err", err, 0);
    tick();
    chk("t1_done_once", done, 0);

    // 2: ack on the 10th REQ cycle still succeeds; then timeout on step 2.
    go();
    do_step(0, 10, 0);
    do_step(1, 1, 0);
    for (int r = 0; r <= RTY; r++) begin
      repeat (9) tick();
      chk("t2_req_c10", step_req, 1);
      tick();
      chk("t2_req_lo", step_req, 0);
      if (r < RTY) begin
        chk("t2_rty_idx", step_idx, 2);
        chk("t2_rty_err", err, 0);
        tick();
      end
    end
    chk("t2_err", err, 1);
    chk("t2_code", err_code, 2);
    chk("t2_step", err_step, 2);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_err_held", {err, err_code, err_step}, {1'b1, 2'b10, 4'd2});
    go();
    chk("t2_restart_idx", step_idx, 0);
    chk("t2_restart_err", {err, err_code, err_step}, 0);
    chk("t2_restart_req", step_req, 1);
    do_abort();
    chk("t2_abort_busy", busy, 0);

    // 3: step 1 reports failure.
    go();
    do_step(0, 1, 0);
    for (int r = 0; r <= RTY; r++) begin
      if (r > 0) tick();
      step_ack = 1'b1; step_fail = 1'b1;
      tick();
      step_ack = 1'b0; step_fail = 1'b0;
      chk("t3_req_lo", step_req, 0);
    end
    chk("t3_err", err, 1);
    chk("t3_code", err_code, 1);
    chk("t3_step", err_step, 1);
    chk("t3_done", done, 0);
    do_abort();
    chk("t3_abort_clr", {err, err_code, err_step, busy}, 0);

    // 4: abort coincident with ack on step 2.
    go();
    do_step(0, 2, 0);
    do_step(1, 2, 0);
    chk("t4_idx", step_idx, 2);
    step_ack = 1'b1; abort = 1'b1;
    tick();
    step_ack = 1'b0; abort = 1'b0;
    chk("t4_req", step_req, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_err", err, 0);
    tick();
    chk("t4_still_idle", {step_req, busy, done}, 0);

    // 5: reset between edges has no effect until the edge.
    go();
    chk("t5_req", step_req, 1);
    rstn = 1'b0;
    #3;
    chk("t5_mid_req", step_req, 1);
    tick();
    chk("t5_rst_outs", {step_req, step_idx, busy, done, err, err_code, err_step}, 0);
    rstn = 1'b1;

`ifdef STEP_SEQ_RETRY_EN
    // 6: step 1 fails twice, then succeeds.
    go();
    do_step(0, 1, 0);
    for (int r = 0; r < 2; r++) begin
      chk("t6_req", step_req, 1);
      chk("t6_idx", step_idx, 1);
      step_ack = 1'b1; step_fail = 1'b1;
      tick();
      step_ack = 1'b0; step_fail = 1'b0;
      chk("t6_gap", step_req, 0);
      chk("t6_gap_idx", step_idx, 1);
      tick();
    end
    do_step(1, 1, 0);
    chk("t6_idx2", step_idx, 2);
    chk("t6_err", err, 0);
    do_abort();
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
